// File: rtl/dacboard_pkg.sv
// Shared constants and helpers for the DAC board: default clocking,
// baud divider and frame sizing, plus the serial receiver state type.
package dacboard_pkg;
  localparam int DEF_CLK_FREQ = 12_000_000;
  localparam int DEF_BAUD     = 230_400;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int frame_bytes(input int sample_bits, input int channels);
    return channels * sample_bits / 8;
  endfunction
endpackage

// File: rtl/uart_audio_rx_if.sv
// Byte stream from the serial receiver to the frame assembler.
interface uart_audio_rx_if;
  logic [7:0] data;
  logic       vld;
  logic       ferr;
  logic       idle;

  modport master (output data, vld, ferr, idle);
  modport slave  (input  data, vld, ferr, idle);
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling, glitch rejection on
// the start bit; emits one-cycle byte-valid or framing-error pulses.
module uart_rx
  import dacboard_pkg::*;
#(
  parameter int DIV = 52
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_i,
  uart_audio_rx_if.master out
);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  logic [1:0]    sync_q;
  logic          prev_q;
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic [7:0]    data_q;
  logic          vld_q;
  logic          ferr_q;
  logic          rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= rx_s;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        RX_IDLE: if (prev_q && !rx_s) begin
          state_q <= RX_START;
          cnt_q   <= '0;
        end
        // a start bit that is high again at mid-bit was a glitch
        RX_START: if (cnt_q == HALF_M1) begin
          cnt_q   <= '0;
          bit_q   <= '0;
          state_q <= rx_s ? RX_IDLE : RX_DATA;
        end else cnt_q <= cnt_q + CW'(1);
        RX_DATA: if (cnt_q == FULL_M1) begin
          cnt_q <= '0;
          sh_q  <= {rx_s, sh_q[7:1]};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= RX_STOP;
        end else cnt_q <= cnt_q + CW'(1);
        RX_STOP: if (cnt_q == FULL_M1) begin
          cnt_q   <= '0;
          state_q <= RX_IDLE;
          if (rx_s) begin
            data_q <= sh_q;
            vld_q  <= 1'b1;
          end else ferr_q <= 1'b1;
        end else cnt_q <= cnt_q + CW'(1);
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign out.data = data_q;
  assign out.vld  = vld_q;
  assign out.ferr = ferr_q;
  assign out.idle = (state_q == RX_IDLE) && rx_s;
endmodule

// File: rtl/uart_audio_rx.sv
// Serial audio receiver: assembles UART bytes into multi-channel frames,
// buffers them in a FIFO and hands one frame out per DAC request.
module uart_audio_rx
  import dacboard_pkg::*;
#(
  parameter int CLK_FREQ    = DEF_CLK_FREQ,
  parameter int BAUD        = DEF_BAUD,
  parameter int SAMPLE_BITS = 16,
  parameter int CHANNELS    = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int IDLE_BITS   = 32
) (
  input  logic                              CLK_IN,
  input  logic                              RST_i,
  input  logic                              UART_RX_i,
  input  logic                              SAMPLE_REQ_i,
  input  logic                              CLEAR_i,
  output logic [CHANNELS*SAMPLE_BITS-1:0]   FRAME_o,
  output logic                              FRAME_VALID_o,
  output logic [$clog2(FIFO_DEPTH):0]       FILL_o,
  output logic                              OVERRUN_o,
  output logic                              UNDERRUN_o,
  output logic                              FRAMING_ERR_o
);
  localparam int DIV      = baud_div(CLK_FREQ, BAUD);
  localparam int FW       = CHANNELS * SAMPLE_BITS;
  localparam int NB       = frame_bytes(SAMPLE_BITS, CHANNELS);
  localparam int IW       = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int IDLE_CYC = IDLE_BITS * DIV;
  localparam int TW       = $clog2(IDLE_CYC + 1);

  uart_audio_rx_if rxb ();

  uart_rx #(.DIV(DIV)) u_rx (
    .clk  (CLK_IN),
    .rst  (RST_i),
    .rx_i (UART_RX_i),
    .out  (rxb)
  );

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [FW-1:0] asm_q, asm_d, asm_full;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          fvld_q, fvld_d;
  logic          ovr_q, ovr_d, und_q, und_d, ferr_q, ferr_d;
  logic          push, pop, wr_en, full, empty, idle_hit;

  always_comb begin
    asm_d    = asm_q;
    idx_d    = idx_q;
    idle_d   = idle_q;
    push     = 1'b0;
    asm_full = asm_q;
    asm_full[{idx_q, 3'b000} +: 8] = rxb.data;
    idle_hit = (idle_q == TW'(IDLE_CYC - 1));

    if (rxb.ferr) idx_d = '0;
    else if (rxb.vld) begin
      asm_d = asm_full;
      if (idx_q == IW'(NB - 1)) begin
        push  = 1'b1;
        idx_d = '0;
      end else idx_d = idx_q + IW'(1);
    end else if (idle_hit) idx_d = '0;

    // only a held partial frame on an idle line ages toward discard
    if (!rxb.idle || idx_q == '0 || idle_hit) idle_d = '0;
    else idle_d = idle_q + TW'(1);

    full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    empty = (cnt_q == '0);
    pop   = SAMPLE_REQ_i && !empty;
    wr_en = push && (!full || pop);

    wr_d  = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    if (wr_en && !pop) cnt_d = cnt_q + (AW+1)'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - (AW+1)'(1);

    frame_d = pop ? mem[rd_q] : frame_q;
    fvld_d  = pop;

    ovr_d  = (ovr_q && !CLEAR_i)  || (push && full && !pop);
    und_d  = (und_q && !CLEAR_i)  || (SAMPLE_REQ_i && empty);
    ferr_d = (ferr_q && !CLEAR_i) || rxb.ferr;
  end

  always_ff @(posedge CLK_IN) begin
    if (wr_en) mem[wr_q] <= asm_full;
  end

  always_ff @(posedge CLK_IN or posedge RST_i) begin
    if (RST_i) begin
      asm_q   <= '0;
      idx_q   <= '0;
      idle_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      fvld_q  <= 1'b0;
      ovr_q   <= 1'b0;
      und_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      fvld_q  <= fvld_d;
      ovr_q   <= ovr_d;
      und_q   <= und_d;
      ferr_q  <= ferr_d;
    end
  end

  assign FRAME_o       = frame_q;
  assign FRAME_VALID_o = fvld_q;
  assign FILL_o        = cnt_q;
  assign OVERRUN_o     = ovr_q;
  assign UNDERRUN_o    = und_q;
  assign FRAMING_ERR_o = ferr_q;
endmodule

// File: tb/tb_uart_audio_rx.sv
// Bench for uart_audio_rx at default parameters: serial stimulus, expected
// frames queued as they are sent and compared when FRAME_VALID_o fires.
module tb_uart_audio_rx;
  localparam int DIV = 52;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        req = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] frame;
  logic        fvld;
  logic [4:0]  fill;
  logic        ovr, und, ferr;

  int n_tests = 0;
  int n_fail  = 0;
  int vcnt    = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  uart_audio_rx dut (
    .CLK_IN        (clk),
    .RST_i         (rst),
    .UART_RX_i     (rx),
    .SAMPLE_REQ_i  (req),
    .CLEAR_i       (clr),
    .FRAME_o       (frame),
    .FRAME_VALID_o (fvld),
    .FILL_o        (fill),
    .OVERRUN_o     (ovr),
    .UNDERRUN_o    (und),
    .FRAMING_ERR_o (ferr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(posedge clk);
    end
    rx = stop;
    repeat (DIV) @(posedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] f);
    for (int i = 0; i < 4; i++) send_byte(f[i*8 +: 8], 1'b1);
  endtask

  task automatic pulse_req();
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && fvld) begin
      vcnt++;
      if (exp_q.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
      else chk("frame", frame, exp_q.pop_front());
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    logic [31:0] f;
    logic [7:0]  k;

    // reset state
    tick(3);
    chk("rst_frame", frame, 0);
    chk("rst_valid", fvld, 0);
    chk("rst_fill", fill, 0);
    chk("rst_flags", {ovr, und, ferr}, 0);
    rst = 1'b0;
    tick(10);

    // underrun from empty FIFO
    v0 = vcnt;
    pulse_req();
    tick(2);
    chk("und_flag", und, 1);
    chk("und_frame", frame, 0);
    chk("und_novalid", vcnt - v0, 0);
    pulse_clr();
    tick(1);
    chk("clr_und", und, 0);

    // basic frame
    send_frame(32'h6100_4000);
    tick(4);
    chk("basic_fill1", fill, 1);
    exp_q.push_back(32'h6100_4000);
    v0 = vcnt;
    pulse_req();
    tick(2);
    chk("basic_fill0", fill, 0);
    chk("basic_one_valid", vcnt - v0, 1);

    // framing error then clean frame
    send_byte(8'h55, 1'b0);
    repeat (2*DIV) @(posedge clk);
    chk("ferr_flag", ferr, 1);
    send_frame(32'h0029_9003);
    tick(4);
    chk("ferr_fill", fill, 1);
    exp_q.push_back(32'h0029_9003);
    pulse_req();
    tick(2);
    pulse_clr();
    tick(1);
    chk("clr_ferr", ferr, 0);

    // error event coinciding with clear keeps the flag
    @(negedge clk); req = 1'b1; clr = 1'b1;
    @(negedge clk); req = 1'b0; clr = 1'b0;
    tick(1);
    chk("clr_coincide_und", und, 1);

    // partial frame discarded after idle timeout
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    repeat (32*DIV) @(posedge clk);
    send_frame(32'h9119_4009);
    tick(4);
    chk("idle_fill", fill, 1);
    exp_q.push_back(32'h9119_4009);
    pulse_req();
    tick(2);
    chk("idle_fill0", fill, 0);

    // reset mid-byte with a frame held and a flag set
    send_frame(32'hDEAD_BEEF);
    tick(4);
    chk("pre_rst_fill", fill, 1);
    rx = 1'b0;
    repeat (3*DIV) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("mid_rst_frame", frame, 0);
    chk("mid_rst_valid", fvld, 0);
    chk("mid_rst_fill", fill, 0);
    chk("mid_rst_flags", {ovr, und, ferr}, 0);
    rx = 1'b1;
    tick(5);
    rst = 1'b0;
    repeat (2*DIV) @(posedge clk);
    send_frame(32'h5634_1240);
    tick(4);
    chk("post_rst_fill", fill, 1);
    exp_q.push_back(32'h5634_1240);
    pulse_req();
    tick(2);

    // overrun: 17 frames, first 16 kept in order
    for (int i = 0; i < 17; i++) begin
      k = 8'(i);
      f = {8'hA0 + k, 8'h50 + k, 8'h30 + k, 8'h10 + k};
      send_frame(f);
      if (i < 16) exp_q.push_back(f);
    end
    tick(4);
    chk("ovr_fill", fill, 16);
    chk("ovr_flag", ovr, 1);
    v0 = vcnt;
    for (int i = 0; i < 16; i++) begin
      pulse_req();
      tick(1);
    end
    tick(2);
    chk("ovr_drain_fill", fill, 0);
    chk("ovr_reads", vcnt - v0, 16);

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_audio_rx.md
UART_AUDIO_RX -- requirements
Module: uart_audio_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 230_400, UART bit rate.
REQ-003 SHALL have parameter SAMPLE_BITS, default 16, bits per sample; multiple of 8, range 8..32.
REQ-004 SHALL have parameter CHANNELS, default 2, samples per frame, range 1..4.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, frames buffered; power of 2.
REQ-006 SHALL have parameter IDLE_BITS, default 32, line-idle bit-times that discard a partial frame.
REQ-007 SHALL have port CLK_IN, input, 1, single clock; all logic on its rising edge.
REQ-008 SHALL have port RST_i, input, 1; reset is asynchronous and active-high.
REQ-009 SHALL have port UART_RX_i, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port SAMPLE_REQ_i, input, 1, one-cycle pulse from the DAC side requesting the next frame.
REQ-011 SHALL have port CLEAR_i, input, 1, clears the sticky error flags.
REQ-012 SHALL have port FRAME_o, output, CHANNELS*SAMPLE_BITS, current frame; ch0 in the LSBs.
REQ-013 SHALL have port FRAME_VALID_o, output, 1, one-cycle pulse when FRAME_o is updated.
REQ-014 SHALL have port FILL_o, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy in frames.
REQ-015 SHALL have ports OVERRUN_o, UNDERRUN_o and FRAMING_ERR_o, outputs, 1 each, sticky error flags.

Function
REQ-016 SHALL pass UART_RX_i through a 2-flop synchroniser before any use.
REQ-017 SHALL receive 8N1, LSB first, with a bit period of DIV = CLK_FREQ/BAUD cycles, rounded down (52 at defaults).
REQ-018 SHALL detect a start bit on a synchronised falling edge, re-check it low at DIV/2, then sample each data bit and the stop bit at DIV intervals from that point.
REQ-019 SHALL abort reception and return to idle without error if the start bit is high at its DIV/2 re-check (glitch).
REQ-020 SHALL, on a stop bit of 0, discard the byte, set FRAMING_ERR_o and reset the assembler to byte 0.
REQ-021 SHALL place received bytes into the frame little-endian within each sample, channels in order ch0 first.
REQ-022 SHALL complete a frame after CHANNELS*SAMPLE_BITS/8 bytes and push it to the FIFO in the cycle after the last stop bit is sampled.
REQ-023 SHALL discard a partial frame and reset the assembler to byte 0 when the line stays idle for IDLE_BITS*DIV cycles with at least one byte held.
REQ-024 SHALL, on a push while FIFO is full with no pop in the same cycle, drop the new frame and set OVERRUN_o.
REQ-025 SHALL, on SAMPLE_REQ_i with FIFO non-empty, load the head frame into FRAME_o and pulse FRAME_VALID_o in the next cycle (latency 1).
REQ-026 SHALL, on SAMPLE_REQ_i with FIFO empty, hold FRAME_o, not pulse FRAME_VALID_o, and set UNDERRUN_o.
REQ-027 SHALL, on a pop and push in the same cycle while full, perform both and accept the new frame; FILL_o is unchanged.
REQ-028 SHALL treat a push and request in the same cycle while empty as an underrun; there is no bypass path.
REQ-029 SHALL update FILL_o in the cycle following each push or pop.
REQ-030 SHALL clear all sticky flags on CLEAR_i; an error event coinciding with CLEAR_i SHALL leave that flag set.
REQ-031 SHALL use rx FSM states IDLE, START, DATA, STOP; IDLE->START on falling edge; START->DATA when line is low at DIV/2, START->IDLE when high; DATA->STOP after bit 7; STOP->IDLE.

Reset
REQ-032 SHALL, while RST_i is high, force FRAME_o=0, FRAME_VALID_o=0, FILL_o=0, all flags=0, FIFO empty, assembler at byte 0 and rx FSM in IDLE, with synchroniser flops at 1.
REQ-033 SHALL abandon any byte in progress when reset is asserted mid-byte, and receive correctly from the next start bit after release.

Structure
REQ-034 SHALL take default CLK_FREQ and BAUD, the divider computation and the bytes-per-frame computation from shared package dacboard_pkg.
REQ-035 SHALL implement the serial receiver (REQ-016..020, REQ-031) as sub-module uart_rx, outputting byte, byte-valid pulse and framing-error pulse.
REQ-036 SHALL implement the FIFO and assembler inline, with storage inferred as an array of FIFO_DEPTH frames.

Verification
REQ-037 SHALL cover: defaults, bytes 00 40 00 61, then SAMPLE_REQ_i -> FRAME_o=32'h6100_4000, one FRAME_VALID_o pulse, FILL_o 1->0.
REQ-038 SHALL cover: SAMPLE_REQ_i after reset with no data -> UNDERRUN_o=1, FRAME_o=0, no FRAME_VALID_o pulse.
REQ-039 SHALL cover: 17 frames sent with no requests -> FILL_o=16, OVERRUN_o=1; 16 reads return the first 16 frames in order.
REQ-040 SHALL cover: one byte with stop bit 0, then 03 90 29 00 -> FRAMING_ERR_o=1 and a single frame 32'h0029_9003.
REQ-041 SHALL cover: 3 bytes, then 32 bit-times idle, then 09 40 19 91 -> only frame 32'h9119_4009 is queued (FILL_o=1).
REQ-042 SHALL cover: RST_i pulsed mid-byte -> all outputs 0 at once; the next byte 0x40 is received correctly.
